// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the EX stage.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ph_q, ph_d;
  logic [WIDTH-1:0] pl_q, pl_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;

  // Multiply: ph accumulates the high half, pl holds the multiplier and fills with product bits.
  assign mul_sum   = {1'b0, ph_q} + (pl_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Divide: ph is the partial remainder, pl shifts the dividend out and quotient bits in.
  assign div_trial = {ph_q, pl_q[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, opnd_q};
  assign div_rem   = {ph_q[WIDTH-2:0], pl_q[WIDTH-1]} - opnd_q;

  assign prod      = {ph_q, pl_q};
  assign prod_fix  = neg_q ? -prod : prod;
  assign q_fix     = neg_q ? -pl_q : pl_q;
  assign r_fix     = rneg_q ? -ph_q : ph_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    pl_d     = pl_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dz_d     = op[1] & (b == '0);
          if (op[1]) begin
            ph_d   = (b == '0) ? a : '0;
            pl_d   = a_abs;
            opnd_d = b_abs;
          end else begin
            ph_d   = '0;
            pl_d   = b_abs;
            opnd_d = a_abs;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        if (dz_q) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            ph_d = div_ge ? div_rem : {ph_q[WIDTH-2:0], pl_q[WIDTH-1]};
            pl_d = {pl_q[WIDTH-2:0], div_ge};
          end else begin
            ph_d = mul_sum[WIDTH:1];
            pl_d = {mul_sum[0], pl_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (dz_q) begin
          hi_d = ph_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    // An exception kills whatever EX holds, including a start, an mt* or a pending result.
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      ph_q     <= '0;
      pl_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      pl_q     <= pl_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q & (start | rd_hilo | mthi | mtlo);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, stall, flush and reset.
`timescale 1ns/1ps
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, mthi, mtlo, rd_hilo, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, stall;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, scnt;

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_hilo(rd_hilo), .flush(flush),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles until busy drops (bounded); also counts cycles with stall high.
  task automatic wait_done(output int c, output int s);
    c = 0; s = 0;
    while (busy && c < 100) begin
      if (stall) s++;
      tick();
      c++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_hilo = 1'b0; flush = 1'b0;
    #12;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    rst_n = 1'b1;
    tick();

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_after_start", {63'd0, busy}, 64'd1);
    wait_done(cyc, scnt);
    chk("multu_latency", 64'(cyc), 64'd33);
    chk("multu_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    issue(2'b00, -32'sd7, 32'd3);
    wait_done(cyc, scnt);
    chk("mult_neg_pos", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(2'b00, -32'sd7, -32'sd3);
    wait_done(cyc, scnt);
    chk("mult_neg_neg", {hi, lo}, 64'h0000_0000_0000_0015);

    issue(2'b10, -32'sd7, 32'd2);
    wait_done(cyc, scnt);
    chk("div_neg_pos", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(2'b10, 32'd7, -32'sd2);
    wait_done(cyc, scnt);
    chk("div_pos_neg", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, scnt);
    chk("div_min_by_m1", {hi, lo}, 64'h0000_0000_8000_0000);

    issue(2'b11, 32'd100, 32'd0);
    rd_hilo = 1'b1;
    #1;
    chk("divzero_stall", {63'd0, stall}, 64'd1);
    wait_done(cyc, scnt);
    chk("divzero_latency", 64'(cyc), 64'd2);
    chk("divzero_result", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    chk("divzero_stall_end", {63'd0, stall}, 64'd0);
    rd_hilo = 1'b0;
    tick();

    issue(2'b00, 32'd6, 32'd7);
    rd_hilo = 1'b1;
    #1;
    chk("mflo_stall_first", {63'd0, stall}, 64'd1);
    tick(); tick(); tick();
    chk("mflo_lo_old_midrun", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    wait_done(cyc, scnt);
    chk("mflo_stall_tracks_busy", 64'(scnt), 64'(cyc));
    chk("mflo_stall_released", {63'd0, stall}, 64'd0);
    chk("mflo_result", {hi, lo}, 64'h0000_0000_0000_002A);
    rd_hilo = 1'b0;

    mthi = 1'b1; wdata = 32'h11;
    #1;
    chk("mthi_same_cycle_old", {32'd0, hi}, 64'd0);
    tick();
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h22;
    tick();
    mtlo = 1'b0;
    chk("mthi_mtlo_idle", {hi, lo}, 64'h0000_0011_0000_0022);

    issue(2'b11, 32'd50, 32'd5);
    for (int i = 0; i < 9; i++) tick();
    chk("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_after", {63'd0, busy}, 64'd0);
    chk("flush_hilo_kept", {hi, lo}, 64'h0000_0011_0000_0022);

    op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start", {63'd0, busy}, 64'd0);

    issue(2'b11, 32'd50, 32'd5);
    wait_done(cyc, scnt);
    chk("divu_50_5", {hi, lo}, 64'h0000_0000_0000_000A);

    issue(2'b01, 32'd2, 32'd3);
    mthi = 1'b1; wdata = 32'h55;
    #1;
    chk("mthi_busy_stall", {63'd0, stall}, 64'd1);
    wait_done(cyc, scnt);
    chk("mthi_busy_result_first", {hi, lo}, 64'h0000_0000_0000_0006);
    tick();
    mthi = 1'b0;
    chk("mthi_after_idle", {32'd0, hi}, 64'h0000_0000_0000_0055);

    issue(2'b00, 32'd5, 32'd5);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", {63'd0, busy}, 64'd0);
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    mthi = 1'b1; wdata = 32'h0000_ABCD;
    tick();
    mthi = 1'b0;
    chk("mthi_after_reset", {hi, lo}, 64'h0000_ABCD_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
